// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed little-endian image from a byte channel into instruction memory.
// Optional trailing-checksum verification is enabled by defining BOOT_LOADER_CHECKSUM_EN.
`default_nettype none

module boot_loader #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_w_enb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
`ifdef BOOT_LOADER_CHECKSUM_EN
        CHECK  = 3'd4,
`endif
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_BITS;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CHECK;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t      state, next_state;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic        accept;
    logic        last_word;
    logic        restart;
    logic [15:0] header_len;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
    logic [7:0]  sum_total;
    assign sum_total = sum + rx_data;
`endif

`ifdef BOOT_LOADER_CHECKSUM_EN
    assign rx_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
`else
    assign rx_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
`endif
    assign busy       = rx_ready;
    assign done       = (state == DONE);
    assign error      = (state == ERROR);
    assign core_rst   = (state != DONE);
    assign accept     = rx_valid && rx_ready;
    assign last_word  = (word_cnt == len - 16'd1);
    assign header_len = {rx_data, len[7:0]};
    assign restart    = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LEN_LO;
            LEN_LO:  if (accept) next_state = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (header_len == 16'd0)
                        next_state = PAYLOAD_END;
                    else if ({1'b0, header_len} > MAX_WORDS)
                        next_state = ERROR;
                    else
                        next_state = DATA;
                end
            end
            DATA:    if (accept && byte_cnt == 2'd3 && last_word) next_state = PAYLOAD_END;
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHECK:   if (accept) next_state = (sum_total == 8'd0) ? DONE : ERROR;
`endif
            DONE:    if (start) next_state = LEN_LO;
            ERROR:   if (start) next_state = LEN_LO;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: the strobe is registered so it lands in the cycle after the 4th byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len        <= 16'd0;
            word_cnt   <= 16'd0;
            byte_cnt   <= 2'd0;
            word_buf   <= 24'd0;
            mem_w_enb  <= 1'b0;
            mem_addr   <= 32'd0;
            mem_w_data <= 32'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum        <= 8'd0;
`endif
        end else begin
            mem_w_enb <= 1'b0;
            if (restart) begin
                word_cnt <= 16'd0;
                byte_cnt <= 2'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                sum      <= 8'd0;
`endif
            end
            if (accept && state == LEN_LO) len[7:0]  <= rx_data;
            if (accept && state == LEN_HI) len[15:8] <= rx_data;
            if (accept && state == DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                sum      <= sum_total;
`endif
                case (byte_cnt)
                    2'd0: word_buf[7:0]   <= rx_data;
                    2'd1: word_buf[15:8]  <= rx_data;
                    2'd2: word_buf[23:16] <= rx_data;
                    default: begin
                        mem_w_enb  <= 1'b1;
                        mem_addr   <= {14'd0, word_cnt, 2'b00};
                        mem_w_data <= {rx_data, word_buf};
                        word_cnt   <= word_cnt + 16'd1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: expected memory writes are queued as bytes are driven.
`default_nettype none

module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_w_enb, core_rst, busy, done, error;
    logic [31:0] mem_addr, mem_w_data;

    boot_loader #(.ADDR_BITS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_w_enb  (mem_w_enb),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;
    logic [31:0] payload[16];

    // Every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (mem_w_enb) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_w_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({mem_addr, mem_w_data} !== exp_w) begin
                    fails++;
                    $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_w_data, exp_w[63:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic gap();
        rx_valid = 1'b0;
        tick(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int c;
        rx_data  = b;
        rx_valid = 1'b1;
        c = 0;
        while (!rx_ready && c < 50) begin
            tick(1);
            c++;
        end
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got rx_ready=0, required 1 within 50 cycles");
        end
        tick(1);
    endtask

    task automatic run_session(input int n, input bit stall);
        logic [7:0]  sum;
        logic [15:0] nn;
        sum = 8'd0;
        nn  = 16'(n);
        pulse_start();
        send_byte(nn[7:0]);
        if (stall) gap();
        send_byte(nn[15:8]);
        if (stall) gap();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({32'(i * 4), payload[i]});
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b;
                b = payload[i][8*k +: 8];
                sum = sum + b;
                send_byte(b);
                if (stall) gap();
            end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h00 - sum);
`endif
        rx_valid = 1'b0;
    endtask

    task automatic check_done_queue(input string name);
        tests++;
        if (done !== 1'b1 || core_rst !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL %s_status: got done=%b core_rst=%b busy=%b error=%b, required 1 0 0 0",
                     name, done, core_rst, busy, error);
        end
        tick(2);
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL %s_writes: got %0d missing writes, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        tests++;
        if ({rx_ready, mem_w_enb, core_rst, busy, done, error} !== 6'b001000) begin
            fails++;
            $display("FAIL reset_flags: got %b, required 001000",
                     {rx_ready, mem_w_enb, core_rst, busy, done, error});
        end
        tests++;
        if (mem_addr !== 32'd0 || mem_w_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_mem: got addr=%h data=%h, required 0 0", mem_addr, mem_w_data);
        end
        rst = 1'b1;
        tick(2);
        tests++;
        if (busy !== 1'b0 || core_rst !== 1'b1) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b core_rst=%b, required 0 1", busy, core_rst);
        end
    endtask

    task automatic test_basic();
        payload[0] = 32'h00000013;
        payload[1] = 32'h00100093;
        run_session(2, 1'b0);
        check_done_queue("basic");
        tests++;
        if (mem_addr !== 32'h4 || mem_w_data !== 32'h00100093 || mem_w_enb !== 1'b0) begin
            fails++;
            $display("FAIL mem_hold: got addr=%h data=%h enb=%b, required 4 00100093 0",
                     mem_addr, mem_w_data, mem_w_enb);
        end
    endtask

    task automatic test_stall();
        payload[0] = 32'h00000013;
        payload[1] = 32'h00100093;
        run_session(2, 1'b1);
        check_done_queue("stall");
    endtask

    task automatic test_zero_len();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        rx_valid = 1'b0;
        check_done_queue("zero_len");
`ifdef BOOT_LOADER_CHECKSUM_EN
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        rx_valid = 1'b0;
        tests++;
        if (error !== 1'b1 || done !== 1'b0 || core_rst !== 1'b1) begin
            fails++;
            $display("FAIL zero_len_bad_sum: got error=%b done=%b core_rst=%b, required 1 0 1",
                     error, done, core_rst);
        end
`endif
    endtask

    task automatic test_overflow();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        rx_valid = 1'b0;
        tick(2);
        tests++;
        if (error !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL overflow: got error=%b core_rst=%b done=%b rx_ready=%b, required 1 1 0 0",
                     error, core_rst, done, rx_ready);
        end
        pulse_start();
        tests++;
        if (error !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL restart_from_error: got error=%b busy=%b rx_ready=%b, required 0 1 1",
                     error, busy, rx_ready);
        end
        // Exactly 2^ADDR_BITS words is legal; abandon it by reset once DATA is reached.
        send_byte(8'h00);
        send_byte(8'h04);
        rx_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL max_len_accepted: got busy=%b error=%b, required 1 0", busy, error);
        end
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_checksum();
`ifdef BOOT_LOADER_CHECKSUM_EN
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        exp_q.push_back({32'h0, 32'h00000013});
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hED);
        rx_valid = 1'b0;
        check_done_queue("checksum_good");
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        exp_q.push_back({32'h0, 32'h00000013});
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEE);
        rx_valid = 1'b0;
        tests++;
        if (error !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL checksum_bad: got error=%b core_rst=%b done=%b, required 1 1 0",
                     error, core_rst, done);
        end
        tick(2);
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL checksum_bad_writes: got %0d missing writes, required 0", exp_q.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        rx_data = 8'h00;
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({rx_ready, mem_w_enb, core_rst, busy, done, error} !== 6'b001000
            || mem_addr !== 32'd0 || mem_w_data !== 32'd0) begin
            fails++;
            $display("FAIL async_reset: got flags=%b addr=%h data=%h, required 001000 0 0",
                     {rx_ready, mem_w_enb, core_rst, busy, done, error}, mem_addr, mem_w_data);
        end
        tick(3);
        rst = 1'b1;
        tick(2);
        rx_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || core_rst !== 1'b1) begin
            fails++;
            $display("FAIL idle_after_release: got busy=%b core_rst=%b, required 0 1", busy, core_rst);
        end
        payload[0] = 32'hDEADBEEF;
        payload[1] = 32'h01234567;
        run_session(2, 1'b0);
        check_done_queue("after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) payload[i] = $urandom;
        run_session(5, 1'b0);
        check_done_queue("b2b_first");
        for (int i = 0; i < 3; i++) payload[i] = $urandom;
        run_session(3, 1'b0);
        check_done_queue("b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_overflow();
        test_checksum();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10; instruction-memory capacity is 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: begin a load session; sampled only in IDLE, DONE and ERROR.
REQ-005 SHALL have port rx_data, input, 8: incoming byte.
REQ-006 SHALL have port rx_valid, input, 1: rx_data is valid.
REQ-007 SHALL have port rx_ready, output, 1: loader can accept a byte; a byte transfers on a cycle where rx_valid and rx_ready are both 1.
REQ-008 SHALL have port mem_w_enb, output, 1: instruction-memory write strobe.
REQ-009 SHALL have port mem_addr, output, 32: instruction-memory byte address.
REQ-010 SHALL have port mem_w_data, output, 32: instruction-memory write word.
REQ-011 SHALL have port core_rst, output, 1: active-high reset to the core; 1 holds the core in reset.
REQ-012 SHALL have ports busy, done and error, output, 1 each: session status.

Function
REQ-013 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE and ERROR; CHECK exists only per REQ-030.
REQ-014 IDLE SHALL go to LEN_LO when start=1.
- DONE and ERROR SHALL also go to LEN_LO when start=1, clearing done, error and the word counter.
- start in any other state SHALL be ignored.
REQ-015 Each accepted byte in LEN_LO SHALL load N[7:0], and each accepted byte in LEN_HI SHALL load N[15:8]; N is a 16-bit word count.
REQ-016 On the LEN_HI byte, if N=0 the loader SHALL go to DONE (to CHECK with REQ-030); if N>2^ADDR_BITS it SHALL go to ERROR; otherwise it SHALL go to DATA.
REQ-017 DATA SHALL assemble words little-endian: byte k of the word goes to bits [8k+7:8k].
REQ-018 On the 4th byte of word i, mem_w_enb SHALL be 1 for exactly the next cycle, with mem_addr=4*i and mem_w_data equal to the assembled word.
REQ-019 rx_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 in all other states.
- Acceptance SHALL continue during the write-strobe cycle, sustaining 1 byte/cycle with no bubbles.
REQ-020 After the 4th byte of word N-1 the loader SHALL go to DONE (to CHECK with REQ-030), so the final strobe coincides with the first DONE/CHECK cycle.
REQ-021 mem_addr and mem_w_data SHALL hold their last values when mem_w_enb=0; mem_w_enb SHALL never be 1 outside the cycle defined in REQ-018.
REQ-022 busy SHALL be 1 in LEN_LO, LEN_HI, DATA and CHECK.
REQ-023 done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-024 core_rst SHALL be 0 only in DONE and 1 in every other state, so the core never runs partial or failed images.
REQ-025 A stalled rx_valid SHALL freeze all state; no timeout.

Reset
REQ-026 Asserting rst (0) SHALL immediately force IDLE with no clock required.
REQ-027 Reset values: rx_ready=0, mem_w_enb=0, mem_addr=0, mem_w_data=0, core_rst=1, busy=0, done=0, error=0, N=0, word counter=0, byte counter=0.
REQ-028 Reset mid-session SHALL abandon the session; already-written words stay in memory and are not rewritten.
REQ-029 Deassertion of rst SHALL take effect on a rising clk edge; the first state change occurs no earlier than the first edge after deassertion.

Configuration
REQ-030 With macro BOOT_LOADER_CHECKSUM_EN defined:
- one trailing byte SHALL follow the payload, accepted in state CHECK;
- if (sum of all payload bytes + trailing byte) mod 256 = 0, the loader SHALL go to DONE, else to ERROR;
- for N=0 the trailing byte SHALL be 0x00 for DONE.
REQ-031 Without BOOT_LOADER_CHECKSUM_EN:
- state CHECK and the sum register SHALL be absent;
- the loader SHALL go directly to DONE per REQ-016 and REQ-020.

Verification
REQ-032 start; bytes 02 00 13 00 00 00 93 00 10 00, one per cycle (macro off) -> writes addr 0x0 data 0x00000013 then addr 0x4 data 0x00100093; done=1; core_rst=0 the cycle after the final strobe.
REQ-033 Same stream with rx_valid toggled 1,0,1,0 -> identical writes; no strobe during stall cycles.
REQ-034 Header 00 00 -> no writes; DONE within 1 cycle (macro off); with macro, trailing 00 -> DONE, trailing 01 -> ERROR.
REQ-035 ADDR_BITS=10, header 01 04 (N=1025) -> ERROR, error=1, core_rst=1, no writes; then start -> LEN_LO with error=0.
REQ-036 Macro on; payload 13 00 00 00 (sum 0x13), trailing ED -> DONE; trailing EE -> ERROR with the word at 0x0 already written and core_rst=1.
REQ-037 rst=0 asserted between the 2nd and 3rd data bytes -> immediate IDLE, all REQ-027 values, no further strobes; a fresh session after release loads correctly.
